iter_comparator: RTL

- Parametrised, multi-cycle successor to the 8-bit GEU comparator in the MiniCPU datapath.
- Compares two WIDTH-bit operands CHUNK bits per cycle, MSB chunk first, under one of eight predicate modes (signed and unsigned).
- Returns an OUT_W-bit all-ones/all-zeros mask plus lt/eq/gt flags through a valid/ready handshake.
- Sits between the ALU issue logic and the writeback mux.

---
 rtl/iter_comparator.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/iter_comparator.sv
// iter_comparator: compares two WIDTH-bit operands CHUNK bits per cycle, MSB
// chunk first, under one of eight signed/unsigned predicates. Returns an
// all-ones/all-zeros mask plus lt/eq/gt flags over a valid/ready handshake.
//
// Build option: ITER_CMP_EARLY_EXIT_EN
//   defined   - CMP stops on the first differing chunk (variable latency)
//   undefined - CMP always walks all NCHUNK chunks (data-independent latency)
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start_valid; start_ready=1
// CMP   | comparing chunk idx of the captured operands
// DONE  | result_valid=1, outputs stable until result_ready

`timescale 1ns/1ps

module iter_comparator #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4,
    parameter int OUT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       mode,
    output logic             result_valid,
    input  logic             result_ready,
    output logic [OUT_W-1:0] mask_out,
    output logic             lt,
    output logic             eq,
    output logic             gt,
    output logic             busy
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    typedef enum logic [1:0] {IDLE, CMP, DONE} state_t;

    state_t           state_q, state_n;
    logic [WIDTH-1:0] a_q, a_n, b_q, b_n;
    logic [2:0]       mode_q, mode_n;
    logic [IDX_W-1:0] idx_q, idx_n;
    logic             lt_q, lt_n, eq_q, eq_n, gt_q, gt_n;
    logic [OUT_W-1:0] mask_q, mask_n;
    logic [CHUNK-1:0] ca, cb;
    logic             diff;
    logic [WIDTH-1:0] msb_flip;

    function automatic logic mask_bit(input logic [2:0] m, input logic l,
                                      input logic e, input logic g);
        logic r;
        case (m)
            3'b000, 3'b100: r = g | e;
            3'b001, 3'b101: r = l;
            3'b010:         r = e;
            3'b011:         r = ~e;
            3'b110:         r = g;
            default:        r = l | e;
        endcase
        return r;
    endfunction

    assign start_ready  = (state_q == IDLE);
    assign busy         = (state_q != IDLE);
    assign result_valid = (state_q == DONE);
    assign mask_out     = mask_q;
    assign lt           = lt_q;
    assign eq           = eq_q;
    assign gt           = gt_q;

    // Flipping the MSB of both operands maps two's-complement order onto unsigned order.
    assign msb_flip = {(mode[2:1] == 2'b10), {(WIDTH-1){1'b0}}};

    // Next-state, chunk walk and result computation.
    always_comb begin
        state_n = state_q;
        a_n     = a_q;
        b_n     = b_q;
        mode_n  = mode_q;
        idx_n   = idx_q;
        lt_n    = lt_q;
        eq_n    = eq_q;
        gt_n    = gt_q;
        mask_n  = mask_q;
        ca      = a_q[int'(idx_q)*CHUNK +: CHUNK];
        cb      = b_q[int'(idx_q)*CHUNK +: CHUNK];
        diff    = (ca != cb);
        case (state_q)
            IDLE: begin
                if (start_valid) begin
                    state_n = CMP;
                    a_n     = a ^ msb_flip;
                    b_n     = b ^ msb_flip;
                    mode_n  = mode;
                    idx_n   = IDX_W'(NCHUNK - 1);
                    lt_n    = 1'b0;
                    eq_n    = 1'b0;
                    gt_n    = 1'b0;
                end
            end
            CMP: begin
`ifdef ITER_CMP_EARLY_EXIT_EN
                if (diff) begin
                    gt_n    = (ca > cb);
                    lt_n    = (ca < cb);
                    state_n = DONE;
                end else if (idx_q == '0) begin
                    eq_n    = 1'b1;
                    state_n = DONE;
                end else begin
                    idx_n = idx_q - IDX_W'(1);
                end
`else
                // Only the first (most significant) difference decides the order.
                if (diff && !(lt_q || gt_q)) begin
                    gt_n = (ca > cb);
                    lt_n = (ca < cb);
                end
                if (idx_q == '0) begin
                    eq_n    = !(lt_n || gt_n);
                    state_n = DONE;
                end else begin
                    idx_n = idx_q - IDX_W'(1);
                end
`endif
                if (state_n == DONE)
                    mask_n = {OUT_W{mask_bit(mode_q, lt_n, eq_n, gt_n)}};
            end
            DONE: begin
                if (result_ready)
                    state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_n;
    end

    // Operand, index and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q    <= '0;
            b_q    <= '0;
            mode_q <= '0;
            idx_q  <= '0;
            lt_q   <= 1'b0;
            eq_q   <= 1'b0;
            gt_q   <= 1'b0;
            mask_q <= '0;
        end else begin
            a_q    <= a_n;
            b_q    <= b_n;
            mode_q <= mode_n;
            idx_q  <= idx_n;
            lt_q   <= lt_n;
            eq_q   <= eq_n;
            gt_q   <= gt_n;
            mask_q <= mask_n;
        end
    end

endmodule
